// File: rtl/star.sv
// Row-wise softmax sequencer: streams each row of scores to the CAM-subtract array,
// tracks the row maximum as a one-hot vector, then steps through find-subtract and EXP/LUT phases.
module star #(
  parameter int INPUT_LEN = 4,
  parameter int N_INPUT   = 64,
  parameter int LUT_LEN   = 64
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [7:0]         data,
  output logic               data_req,
  output logic [8:0]         data_addr,
  input  logic [LUT_LEN-1:0] i_xi_MV,
  output logic               CAMSUB_req,
  output logic [7:0]         xi,
  output logic [LUT_LEN-1:0] o_xmax_MV,
  output logic [LUT_LEN-1:0] o_xi_MV,
  output logic               FindSub_req,
  input  logic [LUT_LEN-1:0] i_sub_MV,
  output logic               EXP_req,
  input  logic [31:0]        exp,
  input  logic [31:0]        Sum_exp,
  output logic [LUT_LEN-1:0] o_sub_MV,
  output logic               finish
);

  localparam int ROWS   = N_INPUT / INPUT_LEN;
  localparam int K_W    = $clog2(INPUT_LEN);
  localparam int ROW_W  = $clog2(ROWS + 1);
  localparam int ADDR_W = 9;
  localparam logic [K_W-1:0]   K_LAST   = K_W'(INPUT_LEN - 1);
  localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(ROWS);

  typedef enum logic [2:0] {
    S_IDLE, S_CAMSUB, S_CAMWAIT, S_FINDSUB, S_EXP, S_EXPWAIT, S_DONE
  } state_t;

  state_t              state, state_n;
  logic [K_W-1:0]      k, k_n;
  logic [ROW_W-1:0]    row, row_n;
  logic [ADDR_W-1:0]   addr_n;
  logic [7:0]          xi_hold;
  logic [LUT_LEN-1:0]  acc;
  logic                new_row;
  logic                xi_take;
  logic [63:0]         unused_obs;

  function automatic logic is_onehot(input logic [LUT_LEN-1:0] v);
    return (v != '0) && ((v & (v - 1'b1)) == '0);
  endfunction

  function automatic logic [LUT_LEN-1:0] msb_onehot(input logic [LUT_LEN-1:0] v);
    logic [LUT_LEN-1:0] r;
    r = '0;
    for (int i = 0; i < LUT_LEN; i++) begin
      if (v[i]) begin
        r    = '0;
        r[i] = 1'b1;
      end
    end
    return r;
  endfunction

  // The LUT consumes exp/Sum_exp directly; this block only observes them.
  assign unused_obs = {exp, Sum_exp};

  always_comb begin
    state_n = state;
    k_n     = k;
    row_n   = row;
    case (state)
      S_IDLE: begin
        state_n = S_CAMSUB;
        k_n     = '0;
      end
      S_CAMSUB: begin
        if (k == K_LAST) begin
          state_n = S_CAMWAIT;
          k_n     = '0;
        end else begin
          k_n = k + 1'b1;
        end
      end
      S_CAMWAIT: state_n = S_FINDSUB;
      S_FINDSUB: begin
        if (k == K_LAST) begin
          state_n = S_EXP;
          k_n     = '0;
        end else begin
          k_n = k + 1'b1;
        end
      end
      S_EXP: begin
        if (k == K_LAST) begin
          state_n = S_EXPWAIT;
          k_n     = '0;
        end else begin
          k_n = k + 1'b1;
        end
      end
      S_EXPWAIT: begin
        row_n   = row + 1'b1;
        state_n = (row_n == ROW_LAST) ? S_DONE : S_CAMSUB;
      end
      S_DONE:  state_n = S_DONE;
      default: state_n = S_IDLE;
    endcase
    addr_n = (state_n == S_CAMSUB) ? ADDR_W'(int'(row_n) * INPUT_LEN + int'(k_n)) : '0;
  end

  // Control stage: state, counters and request decodes registered from next state
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state       <= S_IDLE;
      k           <= '0;
      row         <= '0;
      data_req    <= 1'b0;
      CAMSUB_req  <= 1'b0;
      FindSub_req <= 1'b0;
      EXP_req     <= 1'b0;
      finish      <= 1'b0;
      data_addr   <= '0;
    end else begin
      state       <= state_n;
      k           <= k_n;
      row         <= row_n;
      data_req    <= (state_n == S_CAMSUB);
      CAMSUB_req  <= (state_n == S_CAMSUB);
      FindSub_req <= (state_n == S_FINDSUB);
      EXP_req     <= (state_n == S_EXP);
      finish      <= (state_n == S_DONE);
      data_addr   <= addr_n;
    end
  end

  assign new_row = (state_n == S_CAMSUB) && (state != S_CAMSUB);
  assign xi_take = ((state == S_CAMSUB) || (state == S_CAMWAIT)) && is_onehot(i_xi_MV);

  // xi follows the buffer live while streaming and freezes on the last score afterwards
  assign xi = CAMSUB_req ? data : xi_hold;

  // Match-vector stage: xi/max capture during CAM phases, sub vector during EXP phases
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      xi_hold   <= '0;
      acc       <= '0;
      o_xmax_MV <= '0;
      o_xi_MV   <= '0;
      o_sub_MV  <= '0;
    end else begin
      if (state == S_CAMSUB) begin
        xi_hold <= data;
      end
      if (new_row) begin
        acc       <= '0;
        o_xmax_MV <= '0;
      end else if (xi_take) begin
        o_xi_MV   <= i_xi_MV;
        acc       <= acc | i_xi_MV;
        o_xmax_MV <= msb_onehot(acc | i_xi_MV);
      end
      if ((state == S_EXP) || (state == S_EXPWAIT)) begin
        o_sub_MV <= is_onehot(i_sub_MV) ? i_sub_MV : '0;
      end else begin
        o_sub_MV <= '0;
      end
    end
  end

endmodule

// File: tb/tb_star.sv
// Bench for star: directed row table plus random rows, scoreboard of per-row max/xi
// expectations popped when each row enters its find-subtract phase.
module tb_star;

  localparam int IL   = 4;
  localparam int NI   = 64;
  localparam int LL   = 64;
  localparam int ROWS = NI / IL;
  localparam int FIN_EDGE = 225;

  logic          clk = 1'b0;
  logic          reset;
  logic [7:0]    data;
  logic          data_req;
  logic [8:0]    data_addr;
  logic [LL-1:0] i_xi_MV;
  logic          CAMSUB_req;
  logic [7:0]    xi;
  logic [LL-1:0] o_xmax_MV;
  logic [LL-1:0] o_xi_MV;
  logic          FindSub_req;
  logic [LL-1:0] i_sub_MV;
  logic          EXP_req;
  logic [31:0]   exp_v;
  logic [31:0]   sum_v;
  logic [LL-1:0] o_sub_MV;
  logic          finish;

  star #(.INPUT_LEN(IL), .N_INPUT(NI), .LUT_LEN(LL)) dut (
    .clk(clk), .reset(reset), .data(data), .data_req(data_req), .data_addr(data_addr),
    .i_xi_MV(i_xi_MV), .CAMSUB_req(CAMSUB_req), .xi(xi), .o_xmax_MV(o_xmax_MV),
    .o_xi_MV(o_xi_MV), .FindSub_req(FindSub_req), .i_sub_MV(i_sub_MV), .EXP_req(EXP_req),
    .exp(exp_v), .Sum_exp(sum_v), .o_sub_MV(o_sub_MV), .finish(finish)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  typedef struct {
    int x[4];
    int xmax;
    int xi;
  } vec_t;

  typedef struct {
    logic [LL-1:0] xmax;
    logic [LL-1:0] xi;
  } row_exp_t;

  vec_t            vecs[6];
  row_exp_t        sbq[$];
  row_exp_t        cur;
  logic signed [7:0] mem [0:NI-1];

  task automatic check64(input string name, input logic [63:0] act, input logic [63:0] want);
    n_tests++;
    if (act !== want) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, want, $time);
    end
  endtask

  function automatic logic [LL-1:0] onehot_of(input int idx);
    if (idx < 0) return '0;
    return 64'd1 << idx;
  endfunction

  function automatic logic is1hot(input logic [LL-1:0] v);
    return (v != '0) && ((v & (v - 1'b1)) == '0);
  endfunction

  // CAM environment: value v matches bit v+20; -21 yields no match, 44 yields a double match
  function automatic logic [LL-1:0] cam_mv(input logic [7:0] v);
    int s;
    s = int'($signed(v));
    if (s == -21) return '0;
    if (s == 44) return 64'h8000_0000_0000_0001;
    if (s >= -20 && s <= 43) return 64'd1 << (s + 20);
    return '0;
  endfunction

  function automatic logic [LL-1:0] sub_pat(input int j);
    case (j)
      0:       return 64'd1 << 50;
      1:       return 64'd1 << 40;
      2:       return '0;
      default: return (64'd1 << 50) | (64'd1 << 40);
    endcase
  endfunction

  assign i_xi_MV = cam_mv(xi);

  task automatic set_vec(input int i, input int a, input int b, input int c, input int d,
                         input int xm, input int xv);
    vecs[i].x[0] = a;
    vecs[i].x[1] = b;
    vecs[i].x[2] = c;
    vecs[i].x[3] = d;
    vecs[i].xmax = xm;
    vecs[i].xi   = xv;
  endtask

  task automatic build_run();
    int v;
    int mx;
    int last;
    row_exp_t e;
    sbq.delete();
    last = -1;
    for (int r = 0; r < ROWS; r++) begin
      if (r < 6) begin
        for (int j = 0; j < IL; j++) mem[r*IL+j] = 8'(vecs[r].x[j]);
        e.xmax = onehot_of(vecs[r].xmax);
        e.xi   = onehot_of(vecs[r].xi);
        last   = vecs[r].xi;
      end else begin
        mx = -1;
        for (int j = 0; j < IL; j++) begin
          v = int'($urandom_range(63)) - 20;
          mem[r*IL+j] = 8'(v);
          if (v + 20 > mx) mx = v + 20;
          last = v + 20;
        end
        e.xmax = onehot_of(mx);
        e.xi   = onehot_of(last);
      end
      sbq.push_back(e);
    end
  endtask

  task automatic check_all_zero(input string tag);
    check64({tag, "_data_req"},  64'(data_req), 64'd0);
    check64({tag, "_data_addr"}, 64'(data_addr), 64'd0);
    check64({tag, "_CAMSUB_req"}, 64'(CAMSUB_req), 64'd0);
    check64({tag, "_FindSub_req"}, 64'(FindSub_req), 64'd0);
    check64({tag, "_EXP_req"},   64'(EXP_req), 64'd0);
    check64({tag, "_xi"},        64'(xi), 64'd0);
    check64({tag, "_o_xmax_MV"}, o_xmax_MV, 64'd0);
    check64({tag, "_o_xi_MV"},   o_xi_MV, 64'd0);
    check64({tag, "_o_sub_MV"},  o_sub_MV, 64'd0);
    check64({tag, "_finish"},    64'(finish), 64'd0);
  endtask

  task automatic run_to_finish(input string tag);
    int e;
    e = 0;
    while (e < 400) begin
      @(posedge clk);
      e++;
      #1;
      if (finish) break;
    end
    check64({tag, "_finish_edge"}, 64'(e), 64'(FIN_EDGE));
    repeat (10) @(negedge clk);
    check64({tag, "_finish_sticky"}, 64'(finish), 64'd1);
    check64({tag, "_done_addr"}, 64'(data_addr), 64'd0);
    check64({tag, "_done_reqs"}, 64'({data_req, CAMSUB_req, FindSub_req, EXP_req}), 64'd0);
    check64({tag, "_rows_left"}, 64'(sbq.size()), 64'd0);
  endtask

  // Environment: buffer read, request/address checks, scoreboard pops, sub-vector stimulus
  int            addr_exp;
  int            cs_cnt;
  int            sub_j;
  logic          prev_exp, prev_cs, prev_fs;
  logic [LL-1:0] prev_sub;

  initial begin
    addr_exp = 0; cs_cnt = 0; sub_j = 0;
    prev_exp = 1'b0; prev_cs = 1'b0; prev_fs = 1'b0; prev_sub = '0;
    forever begin
      @(negedge clk);
      if (!reset) begin
        addr_exp = 0; cs_cnt = 0; sub_j = 0;
        prev_exp = 1'b0; prev_cs = 1'b0; prev_fs = 1'b0; prev_sub = '0;
        i_sub_MV = '0;
      end else begin
        check64("o_sub_MV", o_sub_MV, (prev_exp && is1hot(prev_sub)) ? prev_sub : '0);
        if (data_req) begin
          check64("data_addr", 64'(data_addr), 64'(addr_exp));
          addr_exp++;
          data = mem[data_addr];
        end else begin
          data = 8'($urandom);
        end
        if (CAMSUB_req) cs_cnt++;
        if (prev_cs && !CAMSUB_req && addr_exp > 0)
          check64("xi_hold", {56'd0, xi}, {56'd0, mem[addr_exp-1]});
        if (FindSub_req && !prev_fs) begin
          check64("camsub_cycles", 64'(cs_cnt), 64'(IL));
          cs_cnt = 0;
          if (sbq.size() == 0) begin
            check64("sb_underflow", 64'd1, 64'd0);
          end else begin
            cur = sbq.pop_front();
            check64("o_xmax_MV", o_xmax_MV, cur.xmax);
            check64("o_xi_MV", o_xi_MV, cur.xi);
          end
        end
        if (EXP_req) check64("o_xmax_MV_exp", o_xmax_MV, cur.xmax);
        if (EXP_req) begin
          i_sub_MV = sub_pat(sub_j);
          sub_j = (sub_j + 1) % 4;
        end else begin
          i_sub_MV = '0;
        end
        prev_sub = i_sub_MV;
        prev_exp = EXP_req;
        prev_cs  = CAMSUB_req;
        prev_fs  = FindSub_req;
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int fcnt;
    logic pf;
    reset = 1'b1;
    data = '0; i_sub_MV = '0; exp_v = 32'h1234_5678; sum_v = 32'h0badf00d;
    cur.xmax = '0; cur.xi = '0;
    set_vec(0,   3,  -5,  10,   0, 30, 20);
    set_vec(1, -20, -20, -20, -20,  0,  0);
    set_vec(2,  43,  43,  43,  43, 63, 63);
    set_vec(3,   5, -21,  12,  44, 32, 32);
    set_vec(4,  44,  44,  44,  44, -1, 32);
    set_vec(5,  -1,   7,   7,   2, 27, 22);
    #1 reset = 1'b0;
    build_run();
    repeat (3) @(negedge clk);
    check_all_zero("reset");
    reset = 1'b1;
    run_to_finish("run1");

    // Second pass: abort in row 5 find-subtract with an asynchronous reset
    @(negedge clk);
    reset = 1'b0;
    build_run();
    @(negedge clk);
    reset = 1'b1;
    fcnt = 0; pf = 1'b0;
    for (int c = 0; c < 200; c++) begin
      @(negedge clk);
      if (FindSub_req && !pf) fcnt++;
      pf = FindSub_req;
      if (fcnt == 6) break;
    end
    check64("row5_findsub_seen", 64'(fcnt), 64'd6);
    #2 reset = 1'b0;
    #1 check_all_zero("async_reset");
    repeat (2) @(negedge clk);
    build_run();
    reset = 1'b1;
    run_to_finish("run3");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/star.md
Name: star

Overview:
- Row-wise softmax sequencer for the STAR compute-in-memory flow.
- Fetches 8-bit signed input scores from an external input buffer one row at a time, and drives each score to an external CAM-subtract array while collecting one-hot match vectors.
- Tracks the row maximum as a one-hot vector, then sequences the external find-subtract and EXP/LUT phases, forwarding the subtract match vectors to the LUT.
- Asserts a sticky finish once every row has been processed.

Parameters:
- INPUT_LEN, 4: elements per row; legal values 4 or 16.
- N_INPUT, 64: total input elements; equals INPUT_LEN**3 when INPUT_LEN=4 and INPUT_LEN**2 when INPUT_LEN=16. Must be a multiple of INPUT_LEN.
- LUT_LEN, 64: width of all one-hot match vectors. Bit i of a CAM vector encodes value i-20; bit i of a SUB vector encodes value i-50.

Ports:
- clk  in  1  single clock, all DUT state on rising edge
- reset  in  1  asynchronous, active-low reset
- data  in  8  input score, driven by the buffer on the falling edge after data_req
- data_req  out  1  request read of data_addr
- data_addr  out  9  input buffer address
- i_xi_MV  in  LUT_LEN  one-hot CAM match vector for xi
- CAMSUB_req  out  1  CAM-subtract write/search phase active
- xi  out  8  score presented to the CAM, signed
- o_xmax_MV  out  LUT_LEN  one-hot vector of the row maximum
- o_xi_MV  out  LUT_LEN  last accepted xi match vector
- FindSub_req  out  1  subtract (xi - max) phase active
- i_sub_MV  in  LUT_LEN  one-hot match vector of (xi - max)
- EXP_req  out  1  exponent lookup phase active
- exp  in  32  LUT exponent result; observed only, not stored
- Sum_exp  in  32  LUT running sum; observed only, not stored
- o_sub_MV  out  LUT_LEN  registered copy of i_sub_MV sent to the LUT
- finish  out  1  all rows done, sticky

Behaviour:
- Reset (reset=0, async): state=IDLE, row=0, k=0. All outputs are 0, including xi, data_addr, every MV output and finish.
- States, one transition per rising clk edge: IDLE -> CAMSUB -> CAMWAIT -> FINDSUB -> EXP -> EXPWAIT -> (CAMSUB for the next row, or DONE).
- IDLE: lasts 1 cycle after reset release.
- CAMSUB: INPUT_LEN cycles, k=0..INPUT_LEN-1.
  - data_req=1, CAMSUB_req=1, data_addr=row*INPUT_LEN+k.
  - xi is a combinational copy of data.
- CAMWAIT: 1 cycle, all requests low, xi holds its last value.
- FINDSUB: INPUT_LEN cycles with FindSub_req=1.
- EXP: INPUT_LEN cycles with EXP_req=1.
- EXPWAIT: 1 cycle, all requests low. Then row increments; if row reaches N_INPUT/INPUT_LEN, go to DONE.
- DONE: finish=1, all requests 0, data_addr=0. State holds until reset.
- Request signals are registered decodes of state; they change only on the rising edge.
- Row cost is 3*INPUT_LEN+2 cycles. finish rises (3*INPUT_LEN+2)*(N_INPUT/INPUT_LEN)+1 rising edges after reset release: 225 for the defaults.
- xi_MV capture: on each rising edge in CAMSUB or CAMWAIT where i_xi_MV is non-zero and one-hot:
  - o_xi_MV <= i_xi_MV.
  - row OR-accumulator acc |= i_xi_MV.
  - o_xmax_MV <= one-hot of the highest set bit of (acc | i_xi_MV).
  - Zero or multi-hot vectors are ignored, so o_xi_MV holds.
- At the entry to CAMSUB of each new row, acc and o_xmax_MV clear to 0. o_xmax_MV stays stable from CAMWAIT through EXPWAIT of that row.
- sub_MV capture: on each rising edge in EXP or EXPWAIT, o_sub_MV <= i_sub_MV if it is one-hot, else 0. It clears to 0 in all other states.
- Equal scores in a row: the maximum vector is unchanged, because OR-ing the same bit is idempotent.
- Address wraps never; the final address is N_INPUT-1.
- Reset asserted mid-row: immediate return to IDLE with all outputs 0. The sequence restarts at row 0.

Test Plan:
- Reset then run, defaults: CAMSUB_req high exactly 4 cycles per row; data_addr sequence 0,1,2,3 then 4..7; finish rises at edge 225 and stays 1.
- Row {3,-5,10,0}, with the env returning one-hot bit (x+20): o_xi_MV ends at bit 20; o_xmax_MV = bit 30 (value 10) throughout FINDSUB/EXP.
- Row {-20,-20,-20,-20}: o_xmax_MV = bit 0. Next row {43,...} clears the old maximum, giving o_xmax_MV = bit 63.
- EXP phase with i_sub_MV = bit 50 (sub = 0), then bit 40: o_sub_MV follows one cycle later. o_sub_MV = 0 while FindSub_req=1 and after EXPWAIT.
- i_xi_MV = 0 or two bits set during CAMSUB: o_xi_MV and o_xmax_MV are unchanged.
- Reset pulse in row 5 FINDSUB: all outputs go 0 asynchronously; after release data_addr restarts at 0 and finish timing is again 225.
